// File: rtl/data_ram_responder_if.sv
// Data-memory bus between the CPU MEM stage (master) and the data RAM
// responder (slave). Request fields flow master->slave; read data and
// the one-cycle completion strobe flow back.
interface data_ram_responder_if;
  logic        ce;     // request valid
  logic        we;     // 1 = write, 0 = read
  logic [31:0] addr;   // byte address
  logic [3:0]  sel;    // byte-lane enables, bit n = data[8n+7:8n]
  logic [31:0] wdata;  // write data
  logic [31:0] rdata;  // read data
  logic        ready;  // completion strobe, high for exactly one cycle

  modport master (
    output ce, we, addr, sel, wdata,
    input  rdata, ready
  );

  modport slave (
    input  ce, we, addr, sel, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/data_ram_responder.sv
// Data RAM responder for the CPU data-memory port.
// A request is captured in IDLE, waits WAIT_CYCLES extra cycles in BUSY,
// then performs the access and pulses ready for one cycle (RESP).
// Dropping ce during BUSY aborts the request without touching the RAM.
// The RAM array itself is never reset, so its contents survive rst.
module data_ram_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,   // asynchronous, active-low
  data_ram_responder_if.slave bus
);

  localparam int         DEPTH     = 1 << ADDR_W;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_next_s;
  logic                ready_r;
  logic                ready_next_s;
  logic                capture_s;
  logic                commit_s;

  // Request fields frozen at capture time
  logic                we_r;
  logic [ADDR_W-1:0]   idx_r;
  logic [3:0]          sel_r;
  logic [31:0]         wdata_r;

  logic [31:0]         rdata_r;
  logic [31:0]         mem_r [DEPTH];

  logic [ADDR_W-1:0]   idx_s;
  logic                addr_unused_s;

  // Word index; low byte-offset bits and bits above the RAM size alias away
  assign idx_s         = bus.addr[ADDR_W+1:2];
  assign addr_unused_s = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;

  // State, wait counter and ready strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      ready_r <= ready_next_s;
    end
  end

  // Next-state logic: capture, count down, commit or abort
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    ready_next_s = 1'b0;
    capture_s    = 1'b0;
    commit_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ce) begin
          capture_s    = 1'b1;
          cnt_next_s   = WAIT_LOAD;
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!bus.ce) begin
          // Requester withdrew: abort wins over the counter
          state_next_s = ST_IDLE;
        end else if (cnt_r != 4'd0) begin
          cnt_next_s   = cnt_r - 4'd1;
        end else begin
          commit_s     = 1'b1;
          ready_next_s = 1'b1;
          state_next_s = ST_RESP;
        end
      end
      ST_RESP: begin
        // ce of the completing request is still high here; not recaptured
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = 4'd0;
      end
    endcase
  end

  // Capture request fields on acceptance; they stay frozen through BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      idx_r   <= '0;
      sel_r   <= 4'd0;
      wdata_r <= 32'd0;
    end else if (capture_s) begin
      we_r    <= bus.we;
      idx_r   <= idx_s;
      sel_r   <= bus.sel;
      wdata_r <= bus.wdata;
    end else begin
      we_r    <= we_r;
      idx_r   <= idx_r;
      sel_r   <= sel_r;
      wdata_r <= wdata_r;
    end
  end

  // Read data register: loads the full word on a read commit, else holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r <= 32'd0;
    end else if (commit_s && !we_r) begin
      rdata_r <= mem_r[idx_r];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  // RAM byte-lane write on a write commit; array has no reset
  always_ff @(posedge clk) begin
    if (commit_s && we_r) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (sel_r[lane]) begin
          mem_r[idx_r][8*lane +: 8] <= wdata_r[8*lane +: 8];
        end
      end
    end
  end

endmodule
